opb_register_bank_ppc2simulink: RTL and testbench
=================================================

// Module: opb_register_bank_ppc2simulink
// PURPOSE
//  OPB slave bank of NUM_REGS 32-bit software registers written (and read back) by the PPC, driven to fabric.
//  Generalises the single ppc2simulink register: per-register byte-enable writes, out-of-range error ack.
//  Optional one-cycle write strobes. Single clock domain: fabric consumers run on OPB_Clk.
// PARAMETERS
//  C_BASEADDR    32'h01085000  first byte address of window
//  C_HIGHADDR    32'h010850FF  last byte address of window
//  C_OPB_AWIDTH  32            OPB address width
//  C_OPB_DWIDTH  32            OPB data width
//  NUM_REGS      4             register count, 1..64; reg i at C_BASEADDR+4*i
//  RESET_VAL     32'h00000000  reset value of every register
// PORTS
//  OPB_Clk         in   1            sole clock, rising edge
//  OPB_Rst         in   1            synchronous, active-high reset
//  OPB_ABus        in   [0:31]       address, bit 0 = MSB
//  OPB_BE          in   [0:3]        byte enables; BE[0] -> DBus[0:7] = reg[31:24]
//  OPB_DBus        in   [0:31]       write data
//  OPB_RNW         in   1            1 = read, 0 = write
//  OPB_select      in   1            transfer request
//  OPB_seqAddr     in   1            burst hint; ignored (each beat handled singly)
//  Sl_DBus         out  [0:31]       read data, 0 outside ack cycle (OR-bus)
//  Sl_errAck       out  1            error, qualified by Sl_xferAck
//  Sl_retry        out  1            tied 0
//  Sl_toutSup      out  1            tied 0
//  Sl_xferAck      out  1            transfer acknowledge, 1-cycle pulse
//  user_data_out   out  [NUM_REGS*32-1:0]  reg i on bits [32*i+31:32*i]
//  user_wr_strobe  out  [NUM_REGS-1:0]     1-cycle pulse per reg written
// BEHAVIOUR
//  - Reset: all regs = RESET_VAL; FSM IDLE; Sl_DBus, Sl_errAck, Sl_xferAck, user_wr_strobe = 0.
//  - hit = OPB_select & C_BASEADDR <= OPB_ABus <= C_HIGHADDR; idx = (OPB_ABus - C_BASEADDR) >> 2.
//  - FSM IDLE: hit -> ACK, capture RNW/idx/BE/DBus. ACK: Sl_xferAck=1 one cycle -> IDLE, unconditionally.
//  - Latency: hit sampled cycle N -> Sl_xferAck in N+1; min 2 cycles per beat, bursts included.
//  - Write (RNW=0, idx<NUM_REGS): enabled bytes updated on edge ending cycle N; new value on
//    user_data_out in cycle N+1 together with Sl_xferAck; BE=0000 acks, changes nothing.
//  - Read (RNW=1, idx<NUM_REGS): Sl_DBus = reg[idx] in cycle N+1 only, else 0.
//  - idx >= NUM_REGS (inside window): no reg change, Sl_DBus=0, Sl_errAck=Sl_xferAck=1 in N+1.
//  - Misaligned address: ABus[30:31] ignored (word access).
//  - Select held across ACK: a new beat is sampled in the IDLE cycle after ACK, never in ACK itself.
//  - Read after write same reg, consecutive beats: returns new value.
//  - OPB_Rst in ACK cycle: next cycle all outputs at reset values, regs = RESET_VAL, no ack.
//  - Sl_retry, Sl_toutSup constant 0.
// CONFIGURATION
//  - REG_WR_STROBE_EN defined: user_wr_strobe[idx]=1 in cycle N+1 of a valid write with any BE bit set;
//    other bits 0; none on reads, errors or BE=0000.
//  - REG_WR_STROBE_EN undefined: user_wr_strobe constant 0, no strobe logic built.
// TESTING
//  - Reset, NUM_REGS=4: read every reg -> 32'h00000000, Sl_xferAck 1 cycle after select, errAck=0.
//  - Write 0xDEADBEEF to BASE+0x8, BE=1111 -> user_data_out[95:64]=0xDEADBEEF with xferAck;
//    readback = 0xDEADBEEF; strobe=4'b0100 (macro on) / 4'b0000 (macro off).
//  - Then write 0x11223344 to BASE+0x8, BE=0101 -> reg2 = 0xDE22BE44.
//  - Access BASE+0x10 (idx 4), NUM_REGS=4 -> errAck=xferAck=1, Sl_DBus=0, all regs unchanged.
//  - Select held high 6 cycles, seqAddr=1, reads idx 0..2 -> exactly 3 acks, on alternate cycles.
//  - Write beat then OPB_Rst asserted during ACK -> next cycle xferAck=0, all regs 0.

Source files
------------

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing NUM_REGS byte-writable 32-bit registers to fabric, with an error ack
// for in-window addresses past the last register. Define REG_WR_STROBE_EN for per-register write strobes.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01085000,
  parameter logic [31:0] C_HIGHADDR   = 32'h010850FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          NUM_REGS     = 4,
  parameter logic [31:0] RESET_VAL    = 32'h00000000
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  output logic                        Sl_xferAck,
  output logic [NUM_REGS*32-1:0]      user_data_out,
  output logic [NUM_REGS-1:0]         user_wr_strobe,
  output logic                        dbg_state_o
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  // Handshake: a beat is accepted when OPB_select addresses the window while IDLE; it is
  // completed by exactly one Sl_xferAck cycle, which alone qualifies Sl_errAck and Sl_DBus.
  state_t state_q, state_d;

  logic [31:0]   regs_q [NUM_REGS];
  logic [31:0]   regs_d [NUM_REGS];
  logic          rnw_q, rnw_d;
  logic          err_q, err_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [31:0]   addr_w;
  logic [31:0]   offset_w;
  logic [29:0]   word_w;
  logic [IW-1:0] idx_w;
  logic [31:0]   dbus_w;
  logic [3:0]    be_w;
  logic          hit_w;
  logic          in_range_w;
  logic          start_w;
  logic          wr_en_w;

  // Big-endian OPB buses map onto little-endian vectors: BE[0] -> be_w[3] -> bits 31:24.
  assign addr_w     = OPB_ABus;
  assign dbus_w     = OPB_DBus;
  assign be_w       = OPB_BE;
  assign offset_w   = addr_w - C_BASEADDR;
  assign word_w     = offset_w[31:2];
  assign idx_w      = word_w[IW-1:0];
  assign hit_w      = OPB_select && (addr_w >= C_BASEADDR) && (addr_w <= C_HIGHADDR);
  assign in_range_w = (word_w < 30'(NUM_REGS));
  assign start_w    = (state_q == ST_IDLE) && hit_w;
  assign wr_en_w    = start_w && !OPB_RNW && in_range_w;

  always_comb begin
    state_d = state_q;
    rnw_d   = rnw_q;
    err_d   = err_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (hit_w) begin
          state_d = ST_ACK;
          rnw_d   = OPB_RNW;
          err_d   = !in_range_w;
          if (in_range_w) idx_d = idx_w;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Writes land on the accepting edge so the new value is visible alongside the ack.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en_w && (idx_w == IW'(i))) begin
        for (int b = 0; b < 4; b++) begin
          if (be_w[b]) regs_d[i][8*b +: 8] = dbus_w[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q <= ST_IDLE;
      rnw_q   <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      state_q <= state_d;
      rnw_q   <= rnw_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    Sl_xferAck = (state_q == ST_ACK);
    Sl_errAck  = (state_q == ST_ACK) && err_q;
    Sl_DBus    = '0;
    if ((state_q == ST_ACK) && rnw_q && !err_q) Sl_DBus = regs_q[idx_q];
  end

  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;
  assign dbg_state_o = state_q;

  always_comb begin
    user_data_out = '0;
    for (int i = 0; i < NUM_REGS; i++) user_data_out[32*i +: 32] = regs_q[i];
  end

`ifdef REG_WR_STROBE_EN
  logic [NUM_REGS-1:0] strobe_q, strobe_d;

  always_comb begin
    strobe_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      strobe_d[i] = wr_en_w && (|be_w) && (idx_w == IW'(i));
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) strobe_q <= '0;
    else         strobe_q <= strobe_d;
  end

  assign user_wr_strobe = strobe_q;
`else
  assign user_wr_strobe = '0;
`endif

  // Bursts are handled beat by beat and accesses are word-wide.
  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr, offset_w[1:0]};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for opb_register_bank_ppc2simulink: directed scenarios plus random OPB traffic,
// checked each cycle against a register-array model.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h01085000;
  localparam logic [31:0] HIGH = 32'h010850FF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [0:31]  abus = '0;
  logic [0:3]   be_in = '0;
  logic [0:31]  dbus = '0;
  logic         rnw = 1'b0;
  logic         sel = 1'b0;
  logic         seq = 1'b0;
  logic [0:31]  sl_dbus;
  logic         sl_err, sl_retry, sl_tout, sl_ack;
  logic [127:0] ud;
  logic [3:0]   stb;
  logic         dbg_state;

  opb_register_bank_ppc2simulink dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be_in), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
    .Sl_DBus(sl_dbus), .Sl_errAck(sl_err), .Sl_retry(sl_retry), .Sl_toutSup(sl_tout),
    .Sl_xferAck(sl_ack), .user_data_out(ud), .user_wr_strobe(stb), .dbg_state_o(dbg_state)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [4];
  logic        exp_ack = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_dbus = '0;
  logic [3:0]  exp_stb = '0;
  logic        check_en = 1'b0;
  logic [31:0] m_word;
  assign m_word = (abus - BASE) >> 2;

  function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] d,
                                           input logic [0:3] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[31-8*b -: 8] = d[31-8*b -: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_regs[i] <= 32'h0;
      exp_ack <= 1'b0; exp_err <= 1'b0; exp_dbus <= '0; exp_stb <= '0;
    end else if (!exp_ack && sel && abus >= BASE && abus <= HIGH) begin
      exp_ack  <= 1'b1;
      exp_err  <= (m_word >= 4);
      exp_dbus <= '0;
      exp_stb  <= '0;
      if (m_word < 4) begin
        if (rnw) exp_dbus <= m_regs[m_word[1:0]];
        else begin
          m_regs[m_word[1:0]] <= apply_be(m_regs[m_word[1:0]], dbus, be_in);
`ifdef REG_WR_STROBE_EN
          if (be_in != 4'b0000) exp_stb <= 4'b0001 << m_word[1:0];
`endif
        end
      end
    end else begin
      exp_ack <= 1'b0; exp_err <= 1'b0; exp_dbus <= '0; exp_stb <= '0;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("xferAck", sl_ack, exp_ack);
      chk("errAck", sl_err, exp_err);
      chk("Sl_DBus", sl_dbus, exp_dbus);
      chk("user_data_out", ud, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
      chk("user_wr_strobe", stb, exp_stb);
      chk("retry_tout", {sl_retry, sl_tout}, 2'b00);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge in an idle cycle; returns at the negedge of the IDLE cycle after the ack.
  task automatic beat(input logic [31:0] a, input logic r, input logic [0:3] be,
                      input logic [31:0] d, output logic [31:0] g_dbus, output logic g_err,
                      output logic [127:0] g_ud, output logic [3:0] g_stb);
    int n;
    logic got;
    abus = a; rnw = r; be_in = be; dbus = d; sel = 1'b1;
    @(posedge clk); #1 sel = 1'b0;
    n = 0; got = 1'b0;
    g_dbus = '0; g_err = 1'b0; g_ud = '0; g_stb = '0;
    while (n < 4 && !got) begin
      @(negedge clk);
      n++;
      if (sl_ack) begin
        got = 1'b1; g_dbus = sl_dbus; g_err = sl_err; g_ud = ud; g_stb = stb;
      end
    end
    chk("ack_seen", got, 1'b1);
    chk("ack_latency", n, 1);
    @(negedge clk);
  endtask

  logic [31:0]  g_dbus;
  logic         g_err;
  logic [127:0] g_ud;
  logic [3:0]   g_stb;
  logic [3:0]   exp_wr_stb;
  int           acks;
  int           prev_ack;
  int           rd_idx;
  logic [31:0]  hold_exp [3];

  initial begin
`ifdef REG_WR_STROBE_EN
    exp_wr_stb = 4'b0100;
`else
    exp_wr_stb = 4'b0000;
`endif
    repeat (3) @(negedge clk);
    chk("reset_ack", sl_ack, 1'b0);
    chk("reset_regs", ud, 128'h0);
    chk("reset_stb", stb, 4'b0000);
    rst = 1'b0;
    check_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      beat(BASE + 32'(4*i), 1'b1, 4'b1111, 32'h0, g_dbus, g_err, g_ud, g_stb);
      chk("reset_read", g_dbus, 32'h0);
      chk("reset_read_err", g_err, 1'b0);
    end

    beat(BASE + 32'h8, 1'b0, 4'b1111, 32'hDEADBEEF, g_dbus, g_err, g_ud, g_stb);
    chk("wr_full_ud", g_ud[95:64], 32'hDEADBEEF);
    chk("wr_full_stb", g_stb, exp_wr_stb);
    beat(BASE + 32'h8, 1'b1, 4'b1111, 32'h0, g_dbus, g_err, g_ud, g_stb);
    chk("rd_full", g_dbus, 32'hDEADBEEF);

    beat(BASE + 32'h8, 1'b0, 4'b0101, 32'h11223344, g_dbus, g_err, g_ud, g_stb);
    chk("wr_be0101_ud", g_ud[95:64], 32'hDE22BE44);
    beat(BASE + 32'hA, 1'b1, 4'b1111, 32'h0, g_dbus, g_err, g_ud, g_stb);
    chk("rd_be0101_misaligned", g_dbus, 32'hDE22BE44);

    beat(BASE + 32'h10, 1'b0, 4'b1111, 32'hFFFFFFFF, g_dbus, g_err, g_ud, g_stb);
    chk("err_ack", g_err, 1'b1);
    chk("err_dbus", g_dbus, 32'h0);
    chk("err_regs", g_ud, 128'h00000000_DE22BE44_00000000_00000000);
    chk("err_stb", g_stb, 4'b0000);

    beat(BASE + 32'h4, 1'b0, 4'b0000, 32'h12345678, g_dbus, g_err, g_ud, g_stb);
    chk("be0000_regs", g_ud, 128'h00000000_DE22BE44_00000000_00000000);
    chk("be0000_stb", g_stb, 4'b0000);

    // Select held for six cycles as a burst reading regs 0..2.
    hold_exp[0] = 32'h0; hold_exp[1] = 32'h0; hold_exp[2] = 32'hDE22BE44;
    acks = 0; prev_ack = 0; rd_idx = 0;
    abus = BASE; rnw = 1'b1; be_in = 4'b1111; seq = 1'b1; sel = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (sl_ack) begin
        chk("burst_alternate", prev_ack, 0);
        if (acks < 3) chk("burst_data", sl_dbus, hold_exp[acks]);
        acks++;
        abus = BASE + 32'(4*acks);
      end
      prev_ack = sl_ack;
    end
    sel = 1'b0; seq = 1'b0;
    chk("burst_ack_count", acks, 3);
    @(negedge clk);

    // Reset asserted during the ACK cycle of a write.
    abus = BASE + 32'h4; rnw = 1'b0; be_in = 4'b1111; dbus = 32'hA5A5A5A5; sel = 1'b1;
    @(negedge clk);
    sel = 1'b0;
    chk("rst_ack_in_ack", sl_ack, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_after_ack", sl_ack, 1'b0);
    chk("rst_after_regs", ud, 128'h0);
    rst = 1'b0;
    @(negedge clk);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      case ($urandom_range(0, 9))
        0: abus = BASE - 32'(1 + $urandom_range(0, 15));
        1: abus = HIGH + 32'(1 + $urandom_range(0, 15));
        2, 3: abus = BASE + 32'($urandom_range(0, 255));
        default: abus = BASE + 32'($urandom_range(0, 19));
      endcase
      sel   = ($urandom_range(0, 9) < 6);
      rnw   = $urandom_range(0, 1) == 1;
      be_in = 4'($urandom_range(0, 15));
      dbus  = $urandom;
      seq   = $urandom_range(0, 1) == 1;
      rst   = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk);
    sel = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
